// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the execute-stage control and
// the multi-cycle multiply/divide unit.
//   start  - request strobe, sampled only while busy is low
//   opcode - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   a, b   - operands (a is also the MTHI/MTLO source)
//   busy   - operation in progress
//   done   - one-cycle pulse when a mult/div has written hi/lo
//   hi, lo - architectural HI/LO registers
interface mul_div_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic [2:0]           opcode;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] hi;
    logic [WORD_SIZE-1:0] lo;

    modport master (
        output start, opcode, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, opcode, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div.sv
// mul_div: radix-2 multi-cycle multiply/divide unit holding HI/LO.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mul_div_if slave: start/opcode/a/b in, busy/done/hi/lo out
// A mult/div takes WORD_SIZE iteration cycles in RUN plus one FIX cycle
// that applies sign correction and writes HI/LO.
module mul_div #(
    parameter int WORD_SIZE = 32
) (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WORD_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WORD_SIZE-1:0] acc_q, acc_d;
    logic [WORD_SIZE-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WORD_SIZE-1:0]   raw_a_q, raw_a_d; // dividend as given, for divide by zero
    logic [WORD_SIZE-1:0]   hi_q, hi_d;
    logic [WORD_SIZE-1:0]   lo_q, lo_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   div0_q, div0_d;
    logic                   done_q, done_d;

    function automatic logic [WORD_SIZE-1:0] mag(input logic [WORD_SIZE-1:0] v,
                                                 input logic sgn);
        return (sgn && v[WORD_SIZE-1]) ? -v : v;
    endfunction

    logic                   op_signed;
    logic [WORD_SIZE-1:0]   mag_a, mag_b;
    logic [WORD_SIZE:0]     msum;
    logic [WORD_SIZE:0]     rsh, dsub;
    logic                   ge;
    logic [2*WORD_SIZE-1:0] mul_next, div_next, prod;
    logic [WORD_SIZE-1:0]   quo, rem;

    // Iteration datapath.
    always_comb begin
        op_signed = ~bus.opcode[0];
        mag_a     = mag(bus.a, op_signed);
        mag_b     = mag(bus.b, op_signed);

        // Multiply: acc = {partial, multiplier}; add when LSB set, shift right.
        msum     = {1'b0, acc_q[2*WORD_SIZE-1:WORD_SIZE]} +
                   {1'b0, (acc_q[0] ? opnd_q : {WORD_SIZE{1'b0}})};
        mul_next = {msum, acc_q[WORD_SIZE-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; shift left, trial
        // subtract. Bit WORD_SIZE of the difference set means it went negative.
        rsh      = acc_q[2*WORD_SIZE-1:WORD_SIZE-1];
        dsub     = rsh - {1'b0, opnd_q};
        ge       = ~dsub[WORD_SIZE];
        div_next = {(ge ? dsub[WORD_SIZE-1:0] : rsh[WORD_SIZE-1:0]),
                    acc_q[WORD_SIZE-2:0], ge};

        prod = neg_res_q ? -acc_q : acc_q;
        quo  = neg_res_q ? -acc_q[WORD_SIZE-1:0] : acc_q[WORD_SIZE-1:0];
        rem  = neg_rem_q ? -acc_q[2*WORD_SIZE-1:WORD_SIZE]
                         : acc_q[2*WORD_SIZE-1:WORD_SIZE];
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            raw_a_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            raw_a_q   <= raw_a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !bus.opcode[2]) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        raw_a_d   = raw_a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = (state_q == FIX);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.opcode[2]) begin
                        cnt_d     = '0;
                        is_div_d  = bus.opcode[1];
                        raw_a_d   = bus.a;
                        neg_res_d = op_signed & (bus.a[WORD_SIZE-1] ^ bus.b[WORD_SIZE-1]);
                        neg_rem_d = op_signed & bus.a[WORD_SIZE-1];
                        div0_d    = (bus.b == '0);
                        opnd_d    = bus.opcode[1] ? mag_b : mag_a;
                        acc_d     = {{WORD_SIZE{1'b0}}, (bus.opcode[1] ? mag_a : mag_b)};
                    end else if (bus.opcode == 3'd4) begin
                        hi_d = bus.a;
                    end else if (bus.opcode == 3'd5) begin
                        lo_d = bus.a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = is_div_q ? div_next : mul_next;
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod[2*WORD_SIZE-1:WORD_SIZE];
                    lo_d = prod[WORD_SIZE-1:0];
                end else if (div0_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    // Most-negative / -1 needs no special case: magnitudes give
                    // quotient 2^(W-1), remainder 0, and the quotient sign is positive.
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && bus.start && bus.opcode[2:1] == 2'b11)
            $warning("mul_div: reserved opcode %0d ignored", bus.opcode);
    end
`endif

endmodule

// File: tb/tb_mul_div.sv
module tb_mul_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_if #(.WORD_SIZE(32)) bus32 ();
    mul_div_if #(.WORD_SIZE(8))  bus8 ();

    mul_div #(.WORD_SIZE(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mul_div #(.WORD_SIZE(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Architectural result of one operation, returned as {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint p;
        logic [63:0] u;
        int q, r;
        case (op)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            3'd1: begin
                u = {32'd0, x} * {32'd0, y};
                return u;
            end
            3'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Transaction-level model of the 32-bit unit: a countdown until results land.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_cnt = 0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_cnt = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                {m_hi, m_lo} = m_pend;
                m_done = 1'b1;
            end
        end else if (bus32.start) begin
            if (bus32.opcode <= 3'd3) begin
                m_pend = ref_op(bus32.opcode, bus32.a, bus32.b);
                m_cnt  = 33;
            end else if (bus32.opcode == 3'd4) m_hi = bus32.a;
            else if (bus32.opcode == 3'd5) m_lo = bus32.a;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(bus32.busy), 64'(m_cnt != 0));
            check("done", 64'(bus32.done), 64'(m_done));
            check("hi",   64'(bus32.hi),   64'(m_hi));
            check("lo",   64'(bus32.lo),   64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus32.start = 1'b1; bus32.opcode = op; bus32.a = x; bus32.b = y;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    // Returns at the negedge where done is high; n counts busy cycles seen.
    task automatic wait_done(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus32.done) return;
            if (bus32.busy) n++;
            @(negedge clk);
        end
        check({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    int n;
    int dcount;

    initial begin
        bus32.start = 1'b0; bus32.opcode = '0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.opcode  = '0; bus8.a  = '0; bus8.b  = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", 64'(bus32.hi), 64'd0);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu", n);
        check("multu_busy_len", 64'(n), 64'd33);
        check("multu_hi", 64'(bus32.hi), 64'hFFFFFFFE);
        check("multu_lo", 64'(bus32.lo), 64'h00000001);
        @(negedge clk);
        check("multu_done_once", 64'(bus32.done), 64'd0);

        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_done("mult", n);
        check("mult_hi", 64'(bus32.hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(bus32.lo), 64'hFFFFFFEB);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div", n);
        check("div_lo", 64'(bus32.lo), 64'hFFFFFFFD);
        check("div_hi", 64'(bus32.hi), 64'hFFFFFFFF);

        issue(3'd3, 32'd100, 32'd0);
        wait_done("divu0", n);
        check("divu0_hi", 64'(bus32.hi), 64'd100);
        check("divu0_lo", 64'(bus32.lo), 64'hFFFFFFFF);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("divovf", n);
        check("divovf_lo", 64'(bus32.lo), 64'h80000000);
        check("divovf_hi", 64'(bus32.hi), 64'd0);

        issue(3'd2, 32'h00000011, 32'hFFFFFFFB);
        wait_done("div_negb", n);
        check("div_negb_lo", 64'(bus32.lo), 64'hFFFFFFFD);
        check("div_negb_hi", 64'(bus32.hi), 64'd2);

        @(negedge clk);
        bus32.start = 1'b1; bus32.opcode = 3'd4; bus32.a = 32'h1234;
        @(negedge clk);
        check("mthi_hi", 64'(bus32.hi), 64'h1234);
        bus32.opcode = 3'd5; bus32.a = 32'h5678;
        @(negedge clk);
        bus32.start = 1'b0;
        check("mtlo_lo", 64'(bus32.lo), 64'h5678);
        check("mtlo_busy", 64'(bus32.busy), 64'd0);

        issue(3'd6, 32'hDEAD, 32'hBEEF);
        check("rsvd_busy", 64'(bus32.busy), 64'd0);
        check("rsvd_hi", 64'(bus32.hi), 64'h1234);

        issue(3'd3, 32'd17, 32'd5);
        repeat (4) @(negedge clk);
        bus32.start = 1'b1; bus32.opcode = 3'd1; bus32.a = 32'd9; bus32.b = 32'd9;
        @(negedge clk);
        bus32.start = 1'b0; bus32.a = 32'hAAAA5555; bus32.b = 32'h12345678;
        wait_done("divu", n);
        check("divu_lo", 64'(bus32.lo), 64'd3);
        check("divu_hi", 64'(bus32.hi), 64'd2);
        bus32.start = 1'b1; bus32.opcode = 3'd1; bus32.a = 32'd6; bus32.b = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        check("b2b_busy", 64'(bus32.busy), 64'd1);
        wait_done("b2b", n);
        check("b2b_lo", 64'(bus32.lo), 64'd42);
        check("b2b_hi", 64'(bus32.hi), 64'd0);

        issue(3'd0, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", 64'(bus32.busy), 64'd0);
        check("rstmid_hi", 64'(bus32.hi), 64'd0);
        check("rstmid_lo", 64'(bus32.lo), 64'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) dcount++;
        end
        check("rstmid_no_done", 64'(dcount), 64'd0);

        @(negedge clk);
        bus8.start = 1'b1; bus8.opcode = 3'd1; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        n = 0; dcount = 0;
        for (int i = 0; i < 30 && !bus8.done; i++) begin
            if (bus8.busy) n++;
            @(negedge clk);
        end
        check("w8_done", 64'(bus8.done), 64'd1);
        check("w8_busy_len", 64'(n), 64'd9);
        check("w8_hi", 64'(bus8.hi), 64'hFE);
        check("w8_lo", 64'(bus8.lo), 64'h01);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div.md
Name: mul_div

Overview:
- Parametrised multi-cycle multiply/divide unit: the sequential companion to the combinational ALU in the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU by radix-2 iteration and holds results in architectural HI/LO registers; also services MTHI/MTLO.
- Sits beside the ALU in the execute stage. Pipeline control stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WORD_SIZE, 32, operand and HI/LO width; must be >= 4.
- CNT_W, $clog2(WORD_SIZE)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- opcode  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved
- a  input  WORD_SIZE  multiplicand / dividend / MTHI-MTLO source
- b  input  WORD_SIZE  multiplier / divisor
- busy  output  1  operation in progress; new starts ignored
- done  output  1  one-cycle pulse when hi/lo updated by mult/div
- hi  output  WORD_SIZE  HI register (product upper half / remainder)
- lo  output  WORD_SIZE  LO register (product lower half / quotient)

Behaviour:
- Reset, synchronous: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation; hi/lo are cleared, never partially written.
- FSM states IDLE, RUN, FIX. busy = (state != IDLE). All outputs are registered or decoded from registered state.
- IDLE, start=1, opcode 0-3:
  - Latch operand magnitudes: signed ops take two's-complement absolute values; unsigned ops use operands as-is.
  - Latch result-sign flags: quotient/product sign = a[MSB]^b[MSB] for signed ops; remainder sign = a[MSB].
  - counter=0; go to RUN.
- IDLE, start=1, opcode 4/5: hi<=a (MTHI) or lo<=a (MTLO) at that edge. No busy, no done.
- IDLE, start=1, opcode 6/7: ignored. Simulation-only warning under `ifndef SYNTHESIS.
- RUN: one iteration per cycle for exactly WORD_SIZE cycles.
  - Multiply: shift-add into a 2*WORD_SIZE accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - When counter reaches WORD_SIZE-1, go to FIX.
- FIX: apply sign correction (negate product; negate quotient and/or remainder per latched flags), write hi/lo, go to IDLE, done=1 for that next cycle only.
- Latency:
  - start sampled at edge E0; hi/lo valid and busy=0 after edge E0+WORD_SIZE+1; done high during the cycle following that edge.
  - Back-to-back: start may be asserted in the same cycle done is high and is accepted.
- start while busy=1: ignored entirely. Operands and opcode are not re-sampled. Inputs may change freely during RUN.
- hi/lo are stable during RUN/FIX, holding previous values until the FIX edge.
- Divide by zero (b=0, DIV or DIVU): completes with normal latency; hi=a, lo=all ones. No sign correction for this case.
- Signed overflow DIV, a=most-negative, b=-1: lo=most-negative, hi=0.
- MULT/MULTU full 2*WORD_SIZE product: hi=upper half, lo=lower half. No overflow flag.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done one cycle.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> hi=100, lo=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 next edge each; busy, done stay 0.
- DIVU 17/5 started; start MULTU with different operands pulsed during RUN -> ignored; lo=3, hi=2; next start in done cycle accepted.
- Rst asserted at RUN cycle 10 -> next edge busy=0, hi=lo=0, no done pulse; repeat with WORD_SIZE=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 edges.
